// File: rtl/sdram_arbiter_pkg.sv
// Shared types and constants for the two-port SDRAM request arbiter.
package sdram_arb_pkg;

   localparam int ADDR_W  = 23;
   localparam int DATA_W  = 16;
   localparam int FETCH_W = 32;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_ISSUE       = 3'd1,
      ST_WAIT_ACCEPT = 3'd2,
      ST_WAIT_DONE   = 3'd3,
      ST_RESP        = 3'd4
   } arb_state_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bundle of the client (fetch/data) and controller-side signals of the arbiter.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface sdram_arbiter_if;

   logic                               i_req;
   logic [sdram_arb_pkg::ADDR_W-1:0]   i_addr;
   logic                               i_ack;
   logic [sdram_arb_pkg::FETCH_W-1:0]  i_data;

   logic                               d_req;
   logic                               d_we;
   logic [sdram_arb_pkg::ADDR_W-1:0]   d_addr;
   logic [sdram_arb_pkg::DATA_W-1:0]   d_wdata;
   logic                               d_ack;
   logic [sdram_arb_pkg::DATA_W-1:0]   d_rdata;

   logic [sdram_arb_pkg::ADDR_W-1:0]   m_addr;
   logic [sdram_arb_pkg::DATA_W-1:0]   m_wdata;
   logic                               m_read_req;
   logic                               m_write_req;
   logic                               m_instr_mode;
   logic                               m_busy;
   logic                               m_read_ready;
   logic [sdram_arb_pkg::FETCH_W-1:0]  m_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
             m_busy, m_read_ready, m_rdata,
      output i_ack, i_data, d_ack, d_rdata,
             m_addr, m_wdata, m_read_req, m_write_req, m_instr_mode
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
             m_busy, m_read_ready, m_rdata,
      input  i_ack, i_data, d_ack, d_rdata,
             m_addr, m_wdata, m_read_req, m_write_req, m_instr_mode
   );

endinterface

// File: rtl/sdram_arbiter_pick.sv
// Combinational grant decision between the fetch and data ports.
module sdram_arb_pick
   import sdram_arb_pkg::*;
#(
   parameter int DATA_PRIO  = 1,
   parameter int STARVE_MAX = 4,
   parameter int STW        = 3
) (
   input  logic           i_ireq,
   input  logic           i_dreq,
   input  logic           i_last,
   input  logic [STW-1:0] i_starve,
   output logic           o_valid,
   output logic           o_port
);

   // Data wins ties unless fetch is starved (priority mode), or the last winner loses (round-robin).
   always_comb begin
      o_valid = i_ireq | i_dreq;
      o_port  = PORT_D;
      if (DATA_PRIO != 0) begin
         if (i_ireq && (!i_dreq || (int'(i_starve) >= STARVE_MAX))) begin
            o_port = PORT_I;
         end
      end else begin
         if (i_ireq && (!i_dreq || (i_last == PORT_D))) begin
            o_port = PORT_I;
         end
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of the SDRAM controller: one outstanding transaction,
// level request / single-cycle ack toward the clients, pulse request toward the controller.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int DATA_PRIO  = 1,
   parameter int STARVE_MAX = 4,
   parameter int ACCEPT_TO  = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   sdram_arbiter_if.slave  io_bus
);

   localparam int STW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam int TW  = (ACCEPT_TO  < 1) ? 1 : $clog2(ACCEPT_TO + 1);

   arb_state_t          r_state;
   arb_state_t          w_next;
   logic                r_instr;
   logic                r_we;
   logic                r_last;
   logic                r_rr_prev;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_drdata;
   logic [FETCH_W-1:0]  r_idata;
   logic [STW-1:0]      r_starve;
   logic [TW-1:0]       r_tmo;

   logic                w_pick_valid;
   logic                w_pick_port;
   logic                w_grant;
   logic                w_pulse;
   logic                w_rd_done;

   sdram_arb_pick #(
      .DATA_PRIO  (DATA_PRIO),
      .STARVE_MAX (STARVE_MAX),
      .STW        (STW)
   ) u_pick (
      .i_ireq   (io_bus.i_req),
      .i_dreq   (io_bus.d_req),
      .i_last   (r_last),
      .i_starve (r_starve),
      .o_valid  (w_pick_valid),
      .o_port   (w_pick_port)
   );

   // Next-state and per-cycle strobes; the issue pulse is held off while the controller is busy.
   always_comb begin
      w_next    = r_state;
      w_grant   = 1'b0;
      w_pulse   = 1'b0;
      w_rd_done = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_valid) begin
               w_grant = 1'b1;
               w_next  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!io_bus.m_busy) begin
               w_pulse = 1'b1;
               w_next  = ST_WAIT_ACCEPT;
            end
         end
         ST_WAIT_ACCEPT: begin
            if (io_bus.m_busy) begin
               w_next = ST_WAIT_DONE;
            end else if (r_tmo <= TW'(1)) begin
               w_next = ST_ISSUE;
            end
         end
         ST_WAIT_DONE: begin
            if (r_we) begin
               if (!io_bus.m_busy) begin
                  w_next = ST_RESP;
               end
            end else if (io_bus.m_read_ready && !r_rr_prev) begin
               w_rd_done = 1'b1;
               w_next    = ST_RESP;
            end
         end
         ST_RESP: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // State register plus the request latches, starve/timeout counters and read-data holding regs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_instr   <= 1'b0;
         r_we      <= 1'b0;
         r_last    <= PORT_D;
         r_rr_prev <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_drdata  <= '0;
         r_idata   <= '0;
         r_starve  <= '0;
         r_tmo     <= '0;
      end else begin
         r_state   <= w_next;
         r_rr_prev <= io_bus.m_read_ready;
         if (w_grant) begin
            r_last <= w_pick_port;
            if (w_pick_port == PORT_I) begin
               r_instr  <= 1'b1;
               r_we     <= 1'b0;
               r_addr   <= io_bus.i_addr;
               r_wdata  <= '0;
               r_starve <= '0;
            end else begin
               r_instr <= 1'b0;
               r_we    <= io_bus.d_we;
               r_addr  <= io_bus.d_addr;
               r_wdata <= io_bus.d_wdata;
               if (int'(r_starve) < STARVE_MAX) begin
                  r_starve <= r_starve + STW'(1);
               end
            end
         end
         if (w_pulse) begin
            r_tmo <= TW'(ACCEPT_TO);
         end else if ((r_state == ST_WAIT_ACCEPT) && (r_tmo != '0)) begin
            r_tmo <= r_tmo - TW'(1);
         end
         if (w_rd_done) begin
            if (r_instr) begin
               r_idata <= io_bus.m_rdata;
            end else begin
               r_drdata <= io_bus.m_rdata[DATA_W-1:0];
            end
         end
      end
   end

   assign io_bus.m_addr       = r_addr;
   assign io_bus.m_wdata      = r_wdata;
   assign io_bus.m_instr_mode = r_instr;
   assign io_bus.m_read_req   = w_pulse & ~r_we;
   assign io_bus.m_write_req  = w_pulse & r_we;
   assign io_bus.i_ack        = (r_state == ST_RESP) & r_instr;
   assign io_bus.d_ack        = (r_state == ST_RESP) & ~r_instr;
   assign io_bus.i_data       = r_idata;
   assign io_bus.d_rdata      = r_drdata;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: read/fetch paths, D/I grant interleave,
// refresh stall, accept timeout re-issue and mid-transaction reset.
module tb_sdram_arbiter;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   sdram_arbiter_if bus ();

   sdram_arbiter #(
      .DATA_PRIO  (1),
      .STARVE_MAX (4),
      .ACCEPT_TO  (15)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a bounded loop is ever mis-bounded.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1, "[TB] watchdog");
   end

   // Advance to just after the next active edge; inputs are driven here.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One comparison point: counts the check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Drive both client request ports.
   task automatic applyStimulus(input logic ireq, input logic [22:0] iaddr,
                                input logic dreq, input logic dwe,
                                input logic [22:0] daddr, input logic [15:0] dwdata);
      bus.i_req   = ireq;
      bus.i_addr  = iaddr;
      bus.d_req   = dreq;
      bus.d_we    = dwe;
      bus.d_addr  = daddr;
      bus.d_wdata = dwdata;
   endtask

   // Controller model for one well-behaved transaction; returns in the RESP cycle.
   task automatic serveTxn(input logic [31:0] rdata, output int waited, output logic mode,
                           output logic wr, output logic [22:0] addr, output logic [15:0] wdata);
      int n;
      n      = 0;
      waited = -1;
      mode   = 1'b0;
      wr     = 1'b0;
      addr   = '0;
      wdata  = '0;
      #1;
      while (!(bus.m_read_req || bus.m_write_req) && n < 40) begin
         cyc();
         #1;
         n++;
      end
      if (!(bus.m_read_req || bus.m_write_req)) begin
         checkOutput("pulse_timeout", 32'(bus.m_read_req | bus.m_write_req), 32'd1);
         return;
      end
      waited = n;
      mode   = bus.m_instr_mode;
      wr     = bus.m_write_req;
      addr   = bus.m_addr;
      wdata  = bus.m_wdata;
      cyc();
      bus.m_busy = 1'b1;
      #1;
      checkOutput("pulse_width", 32'({bus.m_read_req, bus.m_write_req}), 32'd0);
      cyc();
      bus.m_busy = 1'b0;
      if (!wr) begin
         bus.m_read_ready = 1'b1;
         bus.m_rdata      = rdata;
      end
      cyc();
      bus.m_read_ready = 1'b0;
      #1;
   endtask

   logic [22:0] gotAddr;
   logic [15:0] gotWdata;
   logic        gotMode;
   logic        gotWr;
   int          waited;
   int          pulses;
   int          acks;
   int          gap;
   logic        expInstr;

   // Linear sequence of directed steps.
   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      applyStimulus(1'b0, 23'h0, 1'b0, 1'b0, 23'h0, 16'h0);
      bus.m_busy       = 1'b0;
      bus.m_read_ready = 1'b0;
      bus.m_rdata      = 32'h0;

      // Reset values.
      repeat (3) cyc();
      checkOutput("rst_acks",   32'({bus.i_ack, bus.d_ack}), 32'd0);
      checkOutput("rst_pulses", 32'({bus.m_read_req, bus.m_write_req, bus.m_instr_mode}), 32'd0);
      checkOutput("rst_maddr",  32'(bus.m_addr), 32'd0);
      checkOutput("rst_mwdata", 32'(bus.m_wdata), 32'd0);
      checkOutput("rst_idata",  bus.i_data, 32'd0);
      checkOutput("rst_drdata", 32'(bus.d_rdata), 32'd0);
      rst_n = 1'b1;
      cyc();

      // Data read at 0x000123.
      applyStimulus(1'b0, 23'h0, 1'b1, 1'b0, 23'h000123, 16'h0);
      serveTxn(32'h0000BEEF, waited, gotMode, gotWr, gotAddr, gotWdata);
      checkOutput("t1_latency", 32'(waited), 32'd1);
      checkOutput("t1_mode",    32'({gotMode, gotWr}), 32'd0);
      checkOutput("t1_addr",    32'(gotAddr), 32'h000123);
      checkOutput("t1_acks",    32'({bus.i_ack, bus.d_ack}), 32'b01);
      checkOutput("t1_rdata",   32'(bus.d_rdata), 32'hBEEF);
      bus.d_req = 1'b0;
      cyc();
      checkOutput("t1_ack_drop", 32'(bus.d_ack), 32'd0);

      // Fetch at 0x000040.
      applyStimulus(1'b1, 23'h000040, 1'b0, 1'b0, 23'h0, 16'h0);
      serveTxn(32'h12345678, waited, gotMode, gotWr, gotAddr, gotWdata);
      checkOutput("t2_mode",   32'({gotMode, gotWr}), 32'b10);
      checkOutput("t2_addr",   32'(gotAddr), 32'h000040);
      checkOutput("t2_acks",   32'({bus.i_ack, bus.d_ack}), 32'b10);
      checkOutput("t2_idata",  bus.i_data, 32'h12345678);
      checkOutput("t2_drdata", 32'(bus.d_rdata), 32'hBEEF);
      bus.i_req = 1'b0;
      cyc();
      checkOutput("t2_ack_drop", 32'(bus.i_ack), 32'd0);

      // Both ports held: expect D,D,D,D,I,D,D,D,D,I with one idle cycle between grants.
      applyStimulus(1'b1, 23'h000040, 1'b1, 1'b0, 23'h000200, 16'h0);
      for (int i = 0; i < 10; i++) begin
         expInstr = (i == 4) || (i == 9);
         serveTxn(32'h1000_0000 + 32'(i) * 32'h11, waited, gotMode, gotWr, gotAddr, gotWdata);
         checkOutput($sformatf("t3_grant%0d", i), 32'(gotMode), 32'(expInstr));
         checkOutput($sformatf("t3_addr%0d", i), 32'(gotAddr), expInstr ? 32'h40 : 32'h200);
         checkOutput($sformatf("t3_ack%0d", i), 32'({bus.i_ack, bus.d_ack}), expInstr ? 32'b10 : 32'b01);
         checkOutput($sformatf("t3_wait%0d", i), 32'(waited), (i == 0) ? 32'd1 : 32'd2);
      end
      checkOutput("t3_idata",  bus.i_data, 32'h10000099);
      checkOutput("t3_drdata", 32'(bus.d_rdata), 32'h0088);
      applyStimulus(1'b0, 23'h0, 1'b0, 1'b0, 23'h0, 16'h0);
      cyc();

      // Refresh stall: busy high for 20 cycles during ISSUE, then exactly one write pulse.
      bus.m_busy = 1'b1;
      applyStimulus(1'b0, 23'h0, 1'b1, 1'b1, 23'h000055, 16'h1234);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         #1;
         pulses += int'(bus.m_read_req | bus.m_write_req);
      end
      checkOutput("t4_no_pulse", 32'(pulses), 32'd0);
      checkOutput("t4_maddr",    32'(bus.m_addr), 32'h000055);
      checkOutput("t4_mwdata",   32'(bus.m_wdata), 32'h1234);
      cyc();
      bus.m_busy = 1'b0;
      serveTxn(32'h0, waited, gotMode, gotWr, gotAddr, gotWdata);
      checkOutput("t4_wait",   32'(waited), 32'd0);
      checkOutput("t4_write",  32'({gotMode, gotWr}), 32'b01);
      checkOutput("t4_ack",    32'({bus.i_ack, bus.d_ack}), 32'b01);
      checkOutput("t4_drdata", 32'(bus.d_rdata), 32'h0088);
      bus.d_req = 1'b0;
      cyc();

      // Controller ignores the first pulse: re-issue 16 cycles later.
      applyStimulus(1'b0, 23'h0, 1'b1, 1'b0, 23'h000077, 16'h0);
      cyc();
      #1;
      checkOutput("t5_first_pulse", 32'(bus.m_read_req), 32'd1);
      gap = 0;
      for (int k = 1; k <= 30; k++) begin
         cyc();
         #1;
         if (bus.m_read_req || bus.m_write_req) begin
            gap = k;
            break;
         end
      end
      checkOutput("t5_repulse_gap", 32'(gap), 32'd16);
      serveTxn(32'h0000CAFE, waited, gotMode, gotWr, gotAddr, gotWdata);
      checkOutput("t5_addr",   32'(gotAddr), 32'h000077);
      checkOutput("t5_ack",    32'({bus.i_ack, bus.d_ack}), 32'b01);
      checkOutput("t5_drdata", 32'(bus.d_rdata), 32'hCAFE);
      bus.d_req = 1'b0;
      cyc();

      // Reset while waiting for fetch data; afterwards a write must still wait for busy low.
      applyStimulus(1'b1, 23'h000099, 1'b0, 1'b0, 23'h0, 16'h0);
      cyc();
      #1;
      checkOutput("t6_pulse", 32'({bus.m_read_req, bus.m_instr_mode}), 32'b11);
      cyc();
      bus.m_busy = 1'b1;
      cyc();
      rst_n     = 1'b0;
      bus.i_req = 1'b0;
      cyc();
      checkOutput("t6_rst_ctrl",   32'({bus.m_read_req, bus.m_write_req, bus.m_instr_mode}), 32'd0);
      checkOutput("t6_rst_maddr",  32'(bus.m_addr), 32'd0);
      checkOutput("t6_rst_acks",   32'({bus.i_ack, bus.d_ack}), 32'd0);
      checkOutput("t6_rst_idata",  bus.i_data, 32'd0);
      checkOutput("t6_rst_drdata", 32'(bus.d_rdata), 32'd0);
      rst_n = 1'b1;
      acks = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         #1;
         acks += int'(bus.i_ack | bus.d_ack);
      end
      checkOutput("t6_no_ack", 32'(acks), 32'd0);
      applyStimulus(1'b0, 23'h0, 1'b1, 1'b1, 23'h000300, 16'hA5A5);
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         #1;
         pulses += int'(bus.m_read_req | bus.m_write_req);
      end
      checkOutput("t6_wait_busy", 32'(pulses), 32'd0);
      bus.m_busy = 1'b0;
      serveTxn(32'h0, waited, gotMode, gotWr, gotAddr, gotWdata);
      checkOutput("t6_write",  32'({gotMode, gotWr}), 32'b01);
      checkOutput("t6_addr",   32'(gotAddr), 32'h000300);
      checkOutput("t6_wdata",  32'(gotWdata), 32'hA5A5);
      checkOutput("t6_ack",    32'({bus.i_ack, bus.d_ack}), 32'b01);
      bus.d_req = 1'b0;
      cyc();
      checkOutput("t6_ack_drop", 32'(bus.d_ack), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
